uart_rx_core: RTL

- Serial receive stage behind the board RX pin. Feeds received bytes to the UART top's command/display logic.
- Oversamples the line at 16x baud, validates start and stop bits, majority-votes each bit, and shifts LSB first.
- Holds the received byte in a one-entry buffer with a valid/read handshake, plus overrun and framing status.
- Runs directly from the 10 MHz system clock.

---
 rtl/uart_rx_core.sv | 118 +++++++++++
 1 files changed

// File: rtl/uart_rx_core.sv
// uart_rx_core: 16x oversampled UART receiver with 2-of-3 bit voting and a one-entry byte buffer.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_rx_core #(
  parameter int CLK_HZ   = 10_000_000,
  parameter int BAUD     = 9600,
  parameter int OVS      = 16,
  parameter int TICK_DIV = CLK_HZ / (BAUD * OVS)
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_rx_data,
  input  logic       i_rd,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_valid,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_parity_err,
  output logic       o_busy
);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
  state_t        r_state;
  logic          r_sync1, r_rx_s, r_s7, r_s8;
  logic [TW-1:0] r_tick_cnt;
  logic [3:0]    r_smp, r_bit_cnt;
  logic [7:0]    r_shift;
  logic          w_tick, w_wrap, w_dec, w_maj;
  assign w_tick = r_tick_cnt == TW'(TICK_DIV - 1);
  assign w_wrap = r_smp == 4'(OVS - 1);
  assign w_dec  = w_tick && r_smp == 4'd9;
  assign w_maj  = (r_s7 & r_s8) | (r_s7 & r_rx_s) | (r_s8 & r_rx_s);
  assign o_busy = r_state != IDLE;
`ifdef UART_RX_PARITY_EN
  logic r_par;
`else
  assign o_parity_err = 1'b0;
`endif
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_sync1     <= 1'b1;
      r_rx_s      <= 1'b1;
      r_s7        <= 1'b0;
      r_s8        <= 1'b0;
      r_tick_cnt  <= '0;
      r_smp       <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_state     <= IDLE;
      o_rx_byte   <= '0;
      o_rx_valid  <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par        <= 1'b0;
      o_parity_err <= 1'b0;
`endif
    end else begin
      r_sync1     <= i_rx_data;
      r_rx_s      <= r_sync1;
      r_tick_cnt  <= w_tick ? '0 : r_tick_cnt + 1'b1;
      o_frame_err <= 1'b0;
      if (i_rd && o_rx_valid) o_rx_valid <= 1'b0;
      if (w_tick) begin
        r_smp <= r_smp + 1'b1;
        if (r_smp == 4'd7) r_s7 <= r_rx_s;
        if (r_smp == 4'd8) r_s8 <= r_rx_s;
      end
      case (r_state)
        IDLE: if (!r_rx_s) begin
          r_state    <= START;
          r_tick_cnt <= '0;
          r_smp      <= '0;
        end
        START: if (w_dec && w_maj) r_state <= IDLE;
        else if (w_tick && w_wrap) begin
          r_state   <= DATA;
          r_bit_cnt <= '0;
        end
        DATA: begin
          if (w_dec) begin
            r_shift   <= {w_maj, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
`ifdef UART_RX_PARITY_EN
          if (w_tick && w_wrap && r_bit_cnt == 4'd8) r_state <= PARITY;
`else
          if (w_tick && w_wrap && r_bit_cnt == 4'd8) r_state <= STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (w_dec) r_par <= w_maj;
          if (w_tick && w_wrap) r_state <= STOP;
        end
`endif
        STOP: if (w_dec) begin
          if (w_maj) begin
            o_rx_byte  <= r_shift;
            o_rx_valid <= 1'b1;
            if (o_rx_valid && !i_rd) o_overrun <= 1'b1;
`ifdef UART_RX_PARITY_EN
            o_parity_err <= ^{r_shift, r_par};
`endif
            r_state <= IDLE;
          end else begin
            o_frame_err <= 1'b1;
            r_smp       <= '0;
            r_state     <= BREAK;
          end
        end
        // r_smp doubles as the count of consecutive high ticks on a held-low line
        BREAK: if (!r_rx_s) r_smp <= '0;
        else if (w_tick && r_smp == 4'd15) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
